// File: rtl/stepper_synth_pkg.sv
// Shared state/octave encodings and period width for the stepper tone channels.
package stepper_synth_pkg;

  localparam int unsigned         PERIOD_W   = 24;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = 24'hFFFFFF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAKE = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [1:0] OCT_NORM = 2'd0;
  localparam logic [1:0] OCT_UP   = 2'd1;
  localparam logic [1:0] OCT_DOWN = 2'd2;

endpackage

// File: rtl/stepper_period_calc.sv
// Effective half-period from pitch and octave select: shift, saturate, clamp to MIN_HALF.
// Purely combinational, zero latency, no flow control.
module stepper_period_calc
  import stepper_synth_pkg::*;
#(
  parameter int unsigned MIN_HALF = 2500
) (
  input  logic [PERIOD_W-1:0] pitch,
  input  logic [1:0]          oct_sel,
  output logic [PERIOD_W-1:0] period
);

  localparam logic [PERIOD_W-1:0] MIN_HALF_P = PERIOD_W'(MIN_HALF);

  logic [PERIOD_W-1:0] shifted;

  always_comb begin
    shifted = pitch;
    case (oct_sel)
      OCT_NORM: shifted = pitch;
      OCT_UP:   shifted = pitch >> 1;
      OCT_DOWN: shifted = pitch[PERIOD_W-1] ? PERIOD_MAX : {pitch[PERIOD_W-2:0], 1'b0};
      default:  shifted = pitch;
    endcase
    // Zero stays zero so a halved pitch of 1 is not promoted into a note.
    period = shifted;
    if ((shifted != '0) && (shifted < MIN_HALF_P)) begin
      period = MIN_HALF_P;
    end
  end

endmodule

// File: rtl/stepper_tone_gen.sv
// One stepper channel: enable lead/hold sequencing and a glitch-free STEP square wave.
// Outputs registered; pitch changes apply only at half-period boundaries.
module stepper_tone_gen
  import stepper_synth_pkg::*;
#(
  parameter int unsigned MIN_HALF    = 2500,
  parameter int unsigned ENABLE_LEAD = 50,
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [PERIOD_W-1:0] pitchIn,
  input  logic [7:0]          velIn,
  input  logic [1:0]          octSel,
  output logic                stepOut,
  output logic                enableN,
  output logic                active
);

  localparam int unsigned       LEAD_W    = $clog2(ENABLE_LEAD + 1);
  localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(ENABLE_LEAD - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]          state;
  logic [LEAD_W-1:0]   lead_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [PERIOD_W-1:0] half_cnt;
  logic [PERIOD_W-1:0] cur_period;
  logic [PERIOD_W-1:0] period;
  logic                note_on;

  assign note_on = (pitchIn != '0) && (velIn != '0);

  stepper_period_calc #(
    .MIN_HALF (MIN_HALF)
  ) u_period (
    .pitch   (pitchIn),
    .oct_sel (octSel),
    .period  (period)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      stepOut    <= 1'b0;
      enableN    <= 1'b1;
      active     <= 1'b0;
      lead_cnt   <= '0;
      hold_cnt   <= '0;
      half_cnt   <= '0;
      cur_period <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (note_on) begin
            state    <= WAKE;
            enableN  <= 1'b0;
            lead_cnt <= '0;
          end
        end
        WAKE: begin
          lead_cnt <= lead_cnt + 1'b1;
          if (!note_on) begin
            state   <= IDLE;
            enableN <= 1'b1;
          end else if (lead_cnt == LEAD_LAST) begin
            state      <= RUN;
            cur_period <= period;
            half_cnt   <= '0;
            active     <= 1'b1;
          end
        end
        RUN: begin
          // Note-off wins over a coincident toggle so STEP always parks low.
          if (!note_on) begin
            state    <= HOLD;
            stepOut  <= 1'b0;
            active   <= 1'b0;
            hold_cnt <= '0;
          end else if (half_cnt == cur_period - 1'b1) begin
            stepOut    <= ~stepOut;
            half_cnt   <= '0;
            cur_period <= period;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (note_on) begin
            state      <= RUN;
            cur_period <= period;
            half_cnt   <= '0;
            active     <= 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state   <= IDLE;
            enableN <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_tone_gen.sv
// Directed bench for stepper_tone_gen with MIN_HALF=4, ENABLE_LEAD=3, HOLD_CYCLES=10.
module tb_stepper_tone_gen;

  logic        Clk;
  logic        Reset;
  logic [23:0] pitchIn;
  logic [7:0]  velIn;
  logic [1:0]  octSel;
  logic        stepOut;
  logic        enableN;
  logic        active;

  logic [23:0] calc_pitch;
  logic [1:0]  calc_oct;
  logic [23:0] calc_period;

  int tests = 0;
  int fails = 0;

  stepper_tone_gen #(
    .MIN_HALF    (4),
    .ENABLE_LEAD (3),
    .HOLD_CYCLES (10)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .pitchIn (pitchIn),
    .velIn   (velIn),
    .octSel  (octSel),
    .stepOut (stepOut),
    .enableN (enableN),
    .active  (active)
  );

  stepper_period_calc #(
    .MIN_HALF (4)
  ) calc (
    .pitch   (calc_pitch),
    .oct_sel (calc_oct),
    .period  (calc_period)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Called right after a toggle (or RUN entry): level must hold len-1 cycles, then flip.
  task automatic half(input string tag, input int len, input logic lvl);
    step(len - 1);
    check({tag, "_hold"}, {31'd0, stepOut}, {31'd0, ~lvl});
    step(1);
    check({tag, "_edge"}, {31'd0, stepOut}, {31'd0, lvl});
  endtask

  task automatic calc_check(input string tag, input logic [23:0] p, input logic [1:0] o,
                            input logic [23:0] exp);
    calc_pitch = p;
    calc_oct   = o;
    #1;
    check(tag, {8'd0, calc_period}, {8'd0, exp});
  endtask

  initial begin
    Reset      = 1'b1;
    pitchIn    = '0;
    velIn      = '0;
    octSel     = 2'd0;
    calc_pitch = '0;
    calc_oct   = 2'd0;

    calc_check("calc_up_clamp",   24'd6,       2'd1, 24'd4);
    calc_check("calc_down_sat",   24'h900000,  2'd2, 24'hFFFFFF);
    calc_check("calc_down_edge",  24'h7FFFFF,  2'd2, 24'hFFFFFE);
    calc_check("calc_norm_clamp", 24'd3,       2'd0, 24'd4);
    calc_check("calc_sel3",       24'd9,       2'd3, 24'd9);
    calc_check("calc_up_zero",    24'd1,       2'd1, 24'd0);
    calc_check("calc_down",       24'd5,       2'd2, 24'd10);

    step(2);
    check("rst_step",   {31'd0, stepOut}, 32'd0);
    check("rst_enable", {31'd0, enableN}, 32'd1);
    check("rst_active", {31'd0, active},  32'd0);
    Reset = 1'b0;
    step(1);

    // Basic note: WAKE for 3 cycles, first rise 5 cycles into RUN.
    pitchIn = 24'd5;
    velIn   = 8'd100;
    octSel  = 2'd0;
    step(1);
    check("s1_enable_low", {31'd0, enableN}, 32'd0);
    check("s1_wake_act",   {31'd0, active},  32'd0);
    step(2);
    check("s1_lead_act", {31'd0, active}, 32'd0);
    step(1);
    check("s1_run_act",  {31'd0, active},  32'd1);
    check("s1_run_step", {31'd0, stepOut}, 32'd0);
    half("s1_rise", 5, 1'b1);
    half("s1_fall", 5, 1'b0);

    // Pitch change mid half-period: current half keeps 5, then 8.
    step(2);
    pitchIn = 24'd8;
    step(2);
    check("s2_old_hold", {31'd0, stepOut}, 32'd0);
    step(1);
    check("s2_old_edge", {31'd0, stepOut}, 32'd1);
    half("s2_new_a", 8, 1'b0);
    half("s2_new_b", 8, 1'b1);

    // Octave up on 6 clamps to 4, applied after the running 8-cycle half.
    octSel  = 2'd1;
    pitchIn = 24'd6;
    half("s3_old", 8, 1'b0);
    half("s3_up_a", 4, 1'b1);
    half("s3_up_b", 4, 1'b0);

    // Octave down saturates: after the boundary no further toggle appears.
    octSel  = 2'd2;
    pitchIn = 24'h900000;
    half("s3_last", 4, 1'b1);
    step(20);
    check("s3_sat_step",   {31'd0, stepOut}, 32'd1);
    check("s3_sat_active", {31'd0, active},  32'd1);

    // Note-off: STEP/active drop next cycle, enable held for 10 cycles.
    velIn   = 8'd0;
    pitchIn = 24'd5;
    octSel  = 2'd0;
    step(1);
    check("s4_off_step",   {31'd0, stepOut}, 32'd0);
    check("s4_off_active", {31'd0, active},  32'd0);
    check("s4_off_enable", {31'd0, enableN}, 32'd0);
    step(9);
    check("s4_hold_last", {31'd0, enableN}, 32'd0);
    step(1);
    check("s4_release", {31'd0, enableN}, 32'd1);

    // Re-trigger from HOLD cycle 6: RUN immediately, rise 5 cycles later.
    velIn = 8'd100;
    step(3);
    check("s5_wake_act", {31'd0, active}, 32'd0);
    step(1);
    check("s5_run_act", {31'd0, active}, 32'd1);
    step(2);
    velIn = 8'd0;
    step(1);
    check("s5_hold_act", {31'd0, active}, 32'd0);
    step(5);
    velIn = 8'd100;
    check("s5_hold_en", {31'd0, enableN}, 32'd0);
    step(1);
    check("s5_retrig_act", {31'd0, active},  32'd1);
    check("s5_retrig_en",  {31'd0, enableN}, 32'd0);
    half("s5_rise", 5, 1'b1);

    // Asynchronous reset mid-RUN with STEP high.
    step(2);
    check("s6_pre_step", {31'd0, stepOut}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("s6_async_step",   {31'd0, stepOut}, 32'd0);
    check("s6_async_enable", {31'd0, enableN}, 32'd1);
    check("s6_async_active", {31'd0, active},  32'd0);
    velIn = 8'd0;
    #1 Reset = 1'b0;
    step(1);
    check("s6_idle_enable", {31'd0, enableN}, 32'd1);

    // Two-cycle note pulse dies in WAKE.
    velIn = 8'd100;
    step(1);
    check("s7_wake_en", {31'd0, enableN}, 32'd0);
    step(1);
    velIn = 8'd0;
    check("s7_wake_en2", {31'd0, enableN}, 32'd0);
    step(1);
    check("s7_abort_en", {31'd0, enableN}, 32'd1);
    step(10);
    check("s7_idle_step",   {31'd0, stepOut}, 32'd0);
    check("s7_idle_active", {31'd0, active},  32'd0);
    check("s7_idle_en",     {31'd0, enableN}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
